chamber_pump_sched: RTL and testbench

Scheduler for the single pressure pump shared by two airlock chambers. Each chamber requests fill (pressurize) or drain (depressurize). The block arbitrates round-robin, runs a settle wait and then a timed pump phase on the slow tick, and honours the door interlock. It sits between the per-chamber interlock FSMs and the pump/display logic.

---
 rtl/chamber_pump_sched_pkg.sv | 17 +
 rtl/chamber_pump_sched_tick_countdown.sv | 22 ++
 rtl/chamber_pump_sched.sv | 141 ++++++++++++++
 tb/tb_chamber_pump_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/chamber_pump_sched_pkg.sv
// Shared types and defaults for the two-chamber airlock pump scheduler.
package chamber_pump_sched_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, PUMP, DONE} state_t;

  localparam logic DIR_FILL  = 1'b1;
  localparam logic DIR_DRAIN = 1'b0;

  localparam int DEF_FILL_TICKS  = 7;
  localparam int DEF_DRAIN_TICKS = 8;
  localparam int DEF_WAIT_TICKS  = 5;

  function automatic logic [1:0] chamber_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/chamber_pump_sched_tick_countdown.sv
// Loadable down-counter on the slow tick; shared by the settle and pump phases.
module tick_countdown #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      count <= '0;
    else if (load)                   count <= load_val;
    else if (dec && count != '0)     count <= count - CNT_W'(1);
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/chamber_pump_sched.sv
// Round-robin pump scheduler for two airlock chambers: settle wait, then timed pump.
// Define PUMP_ABORT_EN to abort on an open door; otherwise an open door pauses the operation.
module chamber_pump_sched
  import chamber_pump_sched_pkg::*;
#(
  parameter int FILL_TICKS  = DEF_FILL_TICKS,
  parameter int DRAIN_TICKS = DEF_DRAIN_TICKS,
  parameter int WAIT_TICKS  = DEF_WAIT_TICKS,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       req_fill,
  input  logic [1:0]       req_drain,
  input  logic [1:0]       door_open,
  output logic [1:0]       grant,
  output logic             pumping,
  output logic             direction,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       done,
  output logic             busy,
  output logic [1:0]       fault
);

  localparam int CMAX = 1 << CNT_W;

  if (FILL_TICKS < 1 || FILL_TICKS >= CMAX) begin : g_bad_fill
    $error("FILL_TICKS out of range for CNT_W");
  end
  if (DRAIN_TICKS < 1 || DRAIN_TICKS >= CMAX) begin : g_bad_drain
    $error("DRAIN_TICKS out of range for CNT_W");
  end
  if (WAIT_TICKS < 1 || WAIT_TICKS >= CMAX) begin : g_bad_wait
    $error("WAIT_TICKS out of range for CNT_W");
  end

  state_t           state;
  logic             rr;
  logic [1:0]       elig;
  logic             win_any, win;
  logic             door_owner, abort, adv;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [CNT_W-1:0] cnt_val;

  // A chamber asking for both fill and drain is treated as not asking at all.
  assign elig       = (req_fill ^ req_drain) & ~door_open;
  assign win_any    = |elig;
  assign win        = elig[rr] ? rr : ~rr;
  assign door_owner = |(grant & door_open);

`ifdef PUMP_ABORT_EN
  assign abort = door_owner;
  assign adv   = tick;
`else
  assign abort = 1'b0;
  assign adv   = tick & ~door_owner;
`endif

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: if (win_any) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(WAIT_TICKS);
      end
      SETTLE, PUMP: begin
        if (abort) cnt_load = 1'b1;
        else if (adv) begin
          if (state == SETTLE && cnt_last) begin
            cnt_load = 1'b1;
            cnt_val  = (direction == DIR_FILL) ? CNT_W'(FILL_TICKS) : CNT_W'(DRAIN_TICKS);
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  tick_countdown #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (count),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      grant     <= '0;
      pumping   <= 1'b0;
      direction <= 1'b0;
      done      <= '0;
      busy      <= 1'b0;
      fault     <= '0;
    end else begin
      done  <= '0;
      fault <= '0;
      case (state)
        IDLE: if (win_any) begin
          grant     <= chamber_onehot(win);
          busy      <= 1'b1;
          direction <= req_fill[win];
          state     <= SETTLE;
        end
        SETTLE, PUMP: begin
          if (abort) begin
            fault   <= grant;
            grant   <= '0;
            busy    <= 1'b0;
            pumping <= 1'b0;
            rr      <= ~grant[1];
            state   <= IDLE;
          end else if (adv && cnt_last) begin
            pumping <= (state == SETTLE);
            state   <= (state == SETTLE) ? PUMP : DONE;
          end else if (state == PUMP) begin
            pumping <= ~door_owner;
          end
        end
        DONE: begin
          done  <= grant;
          grant <= '0;
          busy  <= 1'b0;
          rr    <= ~grant[1];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chamber_pump_sched.sv
// Directed bench for chamber_pump_sched with default tick parameters.
module tb_chamber_pump_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] req_fill, req_drain, door_open;
  logic [1:0] grant, done, fault;
  logic       pumping, direction, busy;
  logic [3:0] count;

  int n_chk = 0;
  int n_err = 0;

  chamber_pump_sched dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .req_fill  (req_fill),
    .req_drain (req_drain),
    .door_open (door_open),
    .grant     (grant),
    .pumping   (pumping),
    .direction (direction),
    .count     (count),
    .done      (done),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with tick driven to t; returns at the following negedge.
  task automatic clk1(input logic t);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_fill = '0; req_drain = '0; door_open = '0; tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, grant, 0);
    chk({tag, ".pumping"}, pumping, 0);
    chk({tag, ".dir"}, direction, 0);
    chk({tag, ".count"}, count, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".fault"}, fault, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_fill = '0; req_drain = '0; door_open = '0; tick = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    reset = 1'b1;

    // Chamber 0 fill, tick every 4 clk
    req_fill = 2'b01;
    clk1(1'b0);
    chk("t1.grant", grant, 2'b01);
    chk("t1.count", count, 5);
    chk("t1.dir", direction, 1);
    chk("t1.busy", busy, 1);
    chk("t1.pump0", pumping, 0);
    for (int i = 1; i <= 12; i++) begin
      repeat (3) clk1(1'b0);
      clk1(1'b1);
      chk($sformatf("t1.cnt%0d", i), count, (i < 5) ? 5 - i : (i == 5) ? 7 : 12 - i);
      chk($sformatf("t1.pmp%0d", i), pumping, (i >= 5 && i < 12) ? 1 : 0);
      chk($sformatf("t1.gnt%0d", i), grant, 2'b01);
      chk($sformatf("t1.dn%0d", i), done, 0);
    end
    clk1(1'b0);
    chk("t1.done", done, 2'b01);
    chk("t1.grant_fall", grant, 0);
    chk("t1.busy_fall", busy, 0);
    req_fill = '0;
    clk1(1'b0);
    chk("t1.done_pulse", done, 0);
    chk("t1.idle", grant, 0);

    // rr now points at chamber 1, which asks for both: must be skipped
    req_fill = 2'b11; req_drain = 2'b10;
    clk1(1'b0);
    chk("t3.grant", grant, 2'b01);
    req_fill = 2'b10;
    repeat (12) clk1(1'b1);
    chk("t3.count", count, 0);
    clk1(1'b0);
    chk("t3.done", done, 2'b01);
    for (int i = 0; i < 5; i++) begin
      clk1(1'b1);
      chk($sformatf("t3.never%0d", i), grant, 0);
    end

    // Both drain together after reset; tick on the grant edge is not counted
    do_reset();
    req_drain = 2'b11;
    clk1(1'b1);
    chk("t2.grant0", grant, 2'b01);
    chk("t2.dir0", direction, 0);
    chk("t2.count0", count, 5);
    repeat (5) clk1(1'b1);
    chk("t2.pump_load", count, 8);
    chk("t2.pumping", pumping, 1);
    repeat (8) clk1(1'b1);
    chk("t2.count_end", count, 0);
    chk("t2.grant_hold", grant, 2'b01);
    clk1(1'b1);
    chk("t2.done0", done, 2'b01);
    chk("t2.gap", grant, 0);
    clk1(1'b1);
    chk("t2.grant1", grant, 2'b10);
    chk("t2.count1", count, 5);
    chk("t2.dir1", direction, 0);
    chk("t2.done_clr", done, 0);
    req_drain = '0;
    repeat (13) clk1(1'b1);
    chk("t2.count1_end", count, 0);
    clk1(1'b1);
    chk("t2.done1", done, 2'b10);
    clk1(1'b0);
    chk("t2.idle", grant, 0);

    // Door opens in PUMP at count 4
    do_reset();
    req_fill = 2'b01;
    clk1(1'b0);
    repeat (8) clk1(1'b1);
    chk("t4.count4", count, 4);
    chk("t4.pumping", pumping, 1);
    door_open = 2'b01; req_fill = '0;
`ifdef PUMP_ABORT_EN
    clk1(1'b1);
    chk("t4.fault", fault, 2'b01);
    chk("t4.grant", grant, 0);
    chk("t4.count", count, 0);
    chk("t4.pump_off", pumping, 0);
    chk("t4.no_done", done, 0);
    clk1(1'b0);
    chk("t4.fault_pulse", fault, 0);
    chk("t4.idle", grant, 0);
    door_open = '0;
`else
    for (int i = 0; i < 3; i++) begin
      clk1(1'b1);
      chk($sformatf("t4.hold%0d", i), count, 4);
      chk($sformatf("t4.paused%0d", i), pumping, 0);
      chk($sformatf("t4.gnt%0d", i), grant, 2'b01);
      chk($sformatf("t4.flt%0d", i), fault, 0);
    end
    door_open = '0;
    clk1(1'b0);
    chk("t4.resume", pumping, 1);
    chk("t4.still4", count, 4);
    clk1(1'b1);
    chk("t4.count3", count, 3);
    repeat (3) clk1(1'b1);
    chk("t4.count0", count, 0);
    clk1(1'b0);
    chk("t4.done", done, 2'b01);
    chk("t4.grant_fall", grant, 0);
`endif

    // Async reset in PUMP, then a fresh grant; request dropped mid-SETTLE
    do_reset();
    req_fill = 2'b01;
    clk1(1'b0);
    repeat (6) clk1(1'b1);
    chk("t5.count", count, 6);
    chk("t5.pumping", pumping, 1);
    #2 reset = 1'b0;
    #1 chk_idle("t5.async");
    @(negedge clk);
    reset = 1'b1;
    clk1(1'b0);
    chk("t5.regrant", grant, 2'b01);
    chk("t5.fresh", count, 5);
    chk("t5.dir", direction, 1);
    repeat (2) clk1(1'b1);
    chk("t6.count3", count, 3);
    req_fill = '0;
    repeat (10) clk1(1'b1);
    chk("t6.count0", count, 0);
    chk("t6.grant_hold", grant, 2'b01);
    clk1(1'b0);
    chk("t6.done", done, 2'b01);
    clk1(1'b0);
    chk("t6.idle", grant, 0);
    chk("t6.done_clr", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
